// File: rtl/instruction_fetch_unit.sv
// Fetches 16-bit instructions as two byte reads (low byte first) and offers them downstream via IRValid/IRReady.
// Word is valid 2 cycles after the first ack; while IRReady is low the fetch stops and IR is held.
module instruction_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        Clock,
  input  logic        Reset,
  output logic        MemReq,
  output logic [15:0] MemAddr,
  input  logic        MemAck,
  input  logic [7:0]  MemData,
  input  logic        PCLoad,
  input  logic [15:0] PCLoadValue,
  output logic [15:0] IR,
  output logic        IRValid,
  input  logic        IRReady,
  output logic [15:0] PC
);

  typedef enum logic [1:0] {FETCH_LO, FETCH_HI, HOLD} state_t;
  state_t state;

  assign MemReq  = Reset && (state != HOLD);
  assign MemAddr = PC;

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      PC      <= RESET_PC;
      IR      <= 16'h0000;
      IRValid <= 1'b0;
      state   <= FETCH_LO;
    end else if (PCLoad) begin
      // Redirect wins over a same-cycle ack; a HOLD handshake in this cycle still completes.
      PC      <= PCLoadValue;
      IRValid <= 1'b0;
      state   <= FETCH_LO;
    end else begin
      case (state)
        FETCH_LO: begin
          if (MemAck) begin
            IR[7:0] <= MemData;
            PC      <= PC + 16'd1;
            state   <= FETCH_HI;
          end
        end
        FETCH_HI: begin
          if (MemAck) begin
            IR[15:8] <= MemData;
            PC       <= PC + 16'd1;
            IRValid  <= 1'b1;
            state    <= HOLD;
          end
        end
        HOLD: begin
          if (IRReady) begin
            IRValid <= 1'b0;
            state   <= FETCH_LO;
          end
        end
        default: state <= FETCH_LO;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed vector table followed by a randomized run against a byte-count model.
module tb_instruction_fetch_unit;

  logic        Clock = 1'b0;
  logic        Reset, MemAck, PCLoad, IRReady;
  logic [7:0]  MemData;
  logic [15:0] PCLoadValue;
  logic        MemReq, IRValid;
  logic [15:0] MemAddr, IR, PC;

  logic [7:0]  mem [0:65535];
  int          nvec = 0;
  int          nerr = 0;

  always #5 Clock = ~Clock;
  assign MemData = mem[MemAddr];

  instruction_fetch_unit dut (
    .Clock(Clock), .Reset(Reset), .MemReq(MemReq), .MemAddr(MemAddr),
    .MemAck(MemAck), .MemData(MemData), .PCLoad(PCLoad), .PCLoadValue(PCLoadValue),
    .IR(IR), .IRValid(IRValid), .IRReady(IRReady), .PC(PC)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        rst, ack, ld;
    logic [15:0] ldv;
    logic        rdy;
    logic        req;
    logic [15:0] addr;
    logic        irv, chk_ir;
    logic [15:0] ir, pc;
  } vec_t;

  vec_t tbl [21];

  // Reference state: bytes collected for the current word and the address it started at.
  logic [15:0] m_pc, m_start, m_next;
  int          m_bytes;

  initial begin
    Reset = 1'b0; MemAck = 1'b0; PCLoad = 1'b0; PCLoadValue = 16'h0000; IRReady = 1'b0;
    mem[16'h0000] = 8'h34; mem[16'h0001] = 8'h12; mem[16'h0002] = 8'hAB; mem[16'h0003] = 8'hEE;
    mem[16'h0100] = 8'h11; mem[16'h0101] = 8'h22; mem[16'hFFFF] = 8'hCD;

    //          rst   ack   ld    ldv       rdy  | req   addr      irv   chk   ir        pc
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0001, 1'b0, 1'b0, 16'h0000, 16'h0001};
    for (int i = 2; i <= 6; i++)
      tbl[i] = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0002, 1'b1, 1'b1, 16'h1234, 16'h0002};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0002, 1'b1, 1'b1, 16'h1234, 16'h0002};
    for (int i = 8; i <= 10; i++)
      tbl[i] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0002, 1'b0, 1'b0, 16'h0000, 16'h0002};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0002, 1'b0, 1'b0, 16'h0000, 16'h0002};
    // Redirect during FETCH_HI: the EE byte at 0003 must be dropped, high byte keeps 12.
    tbl[12] = '{1'b1, 1'b1, 1'b1, 16'h0100, 1'b1, 1'b1, 16'h0003, 1'b0, 1'b1, 16'h12AB, 16'h0003};
    tbl[13] = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0100, 1'b0, 1'b0, 16'h0000, 16'h0100};
    tbl[14] = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0101, 1'b0, 1'b0, 16'h0000, 16'h0101};
    // Handshake plus redirect in HOLD, then a fetch wrapping FFFF -> 0000 (which holds 34).
    tbl[15] = '{1'b1, 1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b0, 16'h0102, 1'b1, 1'b1, 16'h2211, 16'h0102};
    tbl[16] = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, 16'h0000, 16'hFFFF};
    tbl[17] = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000};
    // Reset while holding a valid word.
    tbl[18] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0001, 1'b1, 1'b1, 16'h34CD, 16'h0001};
    tbl[19] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 16'h0000};
    tbl[20] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1, 16'h0000, 16'h0000};

    // Reset state, checked while Reset is still low.
    repeat (2) @(negedge Clock);
    #1;
    chk("rst_memreq", 16'(MemReq), 16'h0000);
    chk("rst_irvalid", 16'(IRValid), 16'h0000);
    chk("rst_ir", IR, 16'h0000);
    chk("rst_pc", PC, 16'h0000);

    for (int i = 0; i < 21; i++) begin
      @(negedge Clock);
      Reset = tbl[i].rst; MemAck = tbl[i].ack; PCLoad = tbl[i].ld;
      PCLoadValue = tbl[i].ldv; IRReady = tbl[i].rdy;
      #1;
      chk($sformatf("t%0d_memreq", i), 16'(MemReq), 16'(tbl[i].req));
      chk($sformatf("t%0d_memaddr", i), MemAddr, tbl[i].addr);
      chk($sformatf("t%0d_irvalid", i), 16'(IRValid), 16'(tbl[i].irv));
      chk($sformatf("t%0d_pc", i), PC, tbl[i].pc);
      if (tbl[i].chk_ir) chk($sformatf("t%0d_ir", i), IR, tbl[i].ir);
    end

    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    m_pc = 16'h0000; m_start = 16'h0000; m_bytes = 0;

    for (int c = 0; c < 3000; c++) begin
      @(negedge Clock);
      Reset   = ($urandom_range(99) != 0);
      MemAck  = ($urandom_range(3) != 0);
      IRReady = ($urandom_range(1) == 1);
      PCLoad  = ($urandom_range(15) == 0);
      case ($urandom_range(2))
        0:       PCLoadValue = 16'hFFFF;
        1:       PCLoadValue = 16'hFFFE;
        default: PCLoadValue = 16'($urandom);
      endcase
      #1;
      chk("rnd_memreq", 16'(MemReq), 16'(Reset && (m_bytes != 2)));
      chk("rnd_memaddr", MemAddr, m_pc);
      chk("rnd_pc", PC, m_pc);
      chk("rnd_irvalid", 16'(IRValid), 16'(m_bytes == 2));
      if (m_bytes == 2) begin
        m_next = m_start + 16'd1;
        chk("rnd_ir", IR, {mem[m_next], mem[m_start]});
      end

      if (!Reset) begin
        m_pc = 16'h0000; m_bytes = 0;
      end else if (PCLoad) begin
        m_pc = PCLoadValue; m_bytes = 0;
      end else if (m_bytes < 2 && MemAck) begin
        if (m_bytes == 0) m_start = m_pc;
        m_pc = m_pc + 16'd1;
        m_bytes++;
      end else if (m_bytes == 2 && IRReady) begin
        m_bytes = 0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
